// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus transaction path.
//   up_trans_t : upstream transaction (byte address, burst in 16-bit words)
//   trans_t    : downstream sub-transaction (one-hot chip select, device offset)
//   split_state_e : transaction splitter FSM states
package hyperbus_pkg;

  localparam int unsigned HB_NR_CS        = 2;
  localparam int unsigned HB_BURST_WIDTH  = 12;
  localparam int unsigned HB_ADDR_WIDTH   = 32;
  localparam int unsigned HB_CS_SIZE_LOG2 = 23;
  localparam int unsigned HB_MAX_CHUNK    = 64;
  localparam int unsigned WORD_BYTES      = 2;

  // burst_type: 1 = linear, 0 = wrapped; address_space: 1 = register space
  typedef struct packed {
    logic                      write;
    logic [HB_BURST_WIDTH-1:0] burst;
    logic                      burst_type;
    logic                      address_space;
    logic [HB_ADDR_WIDTH-1:0]  address;
  } up_trans_t;

  typedef struct packed {
    logic [HB_NR_CS-1:0]       cs;
    logic                      write;
    logic [HB_BURST_WIDTH-1:0] burst;
    logic                      burst_type;
    logic                      address_space;
    logic [HB_ADDR_WIDTH-1:0]  address;
  } trans_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ERR
  } split_state_e;

endpackage

// File: rtl/hyperbus_chunk_calc.sv
// Combinational chunk calculator.
//   address, remaining, burst_type, address_space : current position of a transaction
//   len       : words in the next sub-transaction
//   cs        : one-hot chip select decoded from the address
//   offset    : byte offset within the selected device
//   range_err : the transaction starting here cannot be issued
module hyperbus_chunk_calc
  import hyperbus_pkg::*;
#(
  parameter int unsigned NR_CS        = HB_NR_CS,
  parameter int unsigned BURST_WIDTH  = HB_BURST_WIDTH,
  parameter int unsigned ADDR_WIDTH   = HB_ADDR_WIDTH,
  parameter int unsigned CS_SIZE_LOG2 = HB_CS_SIZE_LOG2,
  parameter int unsigned MAX_CHUNK    = HB_MAX_CHUNK
) (
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [BURST_WIDTH-1:0] remaining,
  input  logic                   burst_type,
  input  logic                   address_space,
  output logic [BURST_WIDTH-1:0] len,
  output logic [NR_CS-1:0]       cs,
  output logic [ADDR_WIDTH-1:0]  offset,
  output logic                   range_err
);

  localparam int unsigned MAX_CHUNK_LOG2 = $clog2(MAX_CHUNK);
  localparam int unsigned CS_IDX_W       = ADDR_WIDTH - CS_SIZE_LOG2;
  localparam int unsigned EXT_W          = ADDR_WIDTH + 2;
  localparam logic [EXT_W-1:0] MEM_BYTES = EXT_W'(NR_CS) << CS_SIZE_LOG2;

  logic                   unsplit;
  logic [BURST_WIDTH-1:0] room;
  logic [CS_IDX_W-1:0]    cs_idx;
  logic [EXT_W-1:0]       end_addr;

  // Wrapped and register-space accesses go out as one chunk.
  assign unsplit  = !burst_type || address_space;
  assign room     = BURST_WIDTH'(MAX_CHUNK) - BURST_WIDTH'(address[MAX_CHUNK_LOG2:1]);
  assign cs_idx   = address[ADDR_WIDTH-1:CS_SIZE_LOG2];
  assign end_addr = EXT_W'(address) + EXT_W'(remaining) * EXT_W'(WORD_BYTES);

  always_comb begin
    len = remaining;
    if (!unsplit && (room < remaining)) len = room;
  end

  always_comb begin
    cs = '0;
    for (int unsigned i = 0; i < NR_CS; i++) cs[i] = (cs_idx == CS_IDX_W'(i));
  end

  always_comb begin
    offset = '0;
    offset[CS_SIZE_LOG2-1:0] = address[CS_SIZE_LOG2-1:0];
  end

  // Chunks never cross a MAX_CHUNK boundary and device sizes are multiples of
  // it, so only the end of the whole memory map needs checking here.
  assign range_err = (remaining == '0)
                   || (EXT_W'(address) >= MEM_BYTES)
                   || address[0]
                   || (unsplit && (remaining > BURST_WIDTH'(MAX_CHUNK)))
                   || (end_addr > MEM_BYTES);

endmodule

// File: rtl/hyperbus_trans_splitter.sv
// Splits one upstream HyperBus transaction into sub-transactions that never
// cross a MAX_CHUNK-word boundary or a chip boundary, and merges the per-chunk
// completions back into a single completion.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o      : upstream transaction handshake, in_trans_i payload
//   out_valid_o/out_ready_i    : sub-transaction handshake, out_trans_o payload
//   chunk_done_i/chunk_err_i   : one sub-transaction completed (with error)
//   done_o/err_o               : upstream transaction completed (with error)
module hyperbus_trans_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NR_CS        = HB_NR_CS,
  parameter int unsigned BURST_WIDTH  = HB_BURST_WIDTH,
  parameter int unsigned ADDR_WIDTH   = HB_ADDR_WIDTH,
  parameter int unsigned CS_SIZE_LOG2 = HB_CS_SIZE_LOG2,
  parameter int unsigned MAX_CHUNK    = HB_MAX_CHUNK
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      in_valid_i,
  output logic      in_ready_o,
  input  up_trans_t in_trans_i,
  output logic      out_valid_o,
  input  logic      out_ready_i,
  output trans_t    out_trans_o,
  input  logic      chunk_done_i,
  input  logic      chunk_err_i,
  output logic      done_o,
  output logic      err_o
);

  split_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [BURST_WIDTH-1:0] rem_q;
  logic                   write_q, type_q, space_q;
  logic [BURST_WIDTH:0]   issued_q, done_cnt_q, done_cnt_nxt;
  logic                   err_acc_q, err_nxt;
  logic                   ready_q, done_q, err_q, done_d, err_d;
  logic                   accept, count_done;

  logic [ADDR_WIDTH-1:0]  calc_addr, calc_offset;
  logic [BURST_WIDTH-1:0] calc_rem, calc_len;
  logic                   calc_type, calc_space, calc_err;
  logic [NR_CS-1:0]       calc_cs;

  // One calculator serves both jobs: validating the incoming transaction in
  // IDLE and describing the current chunk otherwise.
  always_comb begin
    calc_addr  = addr_q;
    calc_rem   = rem_q;
    calc_type  = type_q;
    calc_space = space_q;
    if (state_q == ST_IDLE) begin
      calc_addr  = in_trans_i.address;
      calc_rem   = in_trans_i.burst;
      calc_type  = in_trans_i.burst_type;
      calc_space = in_trans_i.address_space;
    end
  end

  hyperbus_chunk_calc #(
    .NR_CS        (NR_CS),
    .BURST_WIDTH  (BURST_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CS_SIZE_LOG2 (CS_SIZE_LOG2),
    .MAX_CHUNK    (MAX_CHUNK)
  ) i_chunk_calc (
    .address       (calc_addr),
    .remaining     (calc_rem),
    .burst_type    (calc_type),
    .address_space (calc_space),
    .len           (calc_len),
    .cs            (calc_cs),
    .offset        (calc_offset),
    .range_err     (calc_err)
  );

  assign accept       = in_valid_i && ready_q;
  // Completions only count once something has been issued downstream.
  assign count_done   = chunk_done_i && (issued_q != '0)
                        && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));
  assign done_cnt_nxt = done_cnt_q + (BURST_WIDTH+1)'(count_done);
  assign err_nxt      = err_acc_q || (count_done && chunk_err_i);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = calc_err ? ST_ERR : ST_ISSUE;
      ST_ISSUE: if (out_ready_i && (rem_q == calc_len)) state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_cnt_nxt == issued_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = err_nxt;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      write_q    <= 1'b0;
      type_q     <= 1'b0;
      space_q    <= 1'b0;
      issued_q   <= '0;
      done_cnt_q <= '0;
      err_acc_q  <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q   <= in_trans_i.address;
        rem_q    <= in_trans_i.burst;
        write_q  <= in_trans_i.write;
        type_q   <= in_trans_i.burst_type;
        space_q  <= in_trans_i.address_space;
        issued_q <= '0;
      end
      if ((state_q == ST_ISSUE) && out_ready_i) begin
        addr_q   <= addr_q + ADDR_WIDTH'(calc_len) * ADDR_WIDTH'(WORD_BYTES);
        rem_q    <= rem_q - calc_len;
        issued_q <= issued_q + (BURST_WIDTH+1)'(1);
      end
      if (count_done) begin
        done_cnt_q <= done_cnt_nxt;
        err_acc_q  <= err_nxt;
      end
      if ((state_q == ST_WAIT) && (state_d == ST_IDLE)) begin
        done_cnt_q <= '0;
        issued_q   <= '0;
        err_acc_q  <= 1'b0;
      end
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (state_q == ST_ISSUE);
  assign done_o      = done_q;
  assign err_o       = err_q;

  always_comb begin
    out_trans_o = '0;
    if (out_valid_o) begin
      out_trans_o.cs            = calc_cs;
      out_trans_o.write         = write_q;
      out_trans_o.burst         = calc_len;
      out_trans_o.burst_type    = type_q;
      out_trans_o.address_space = space_q;
      out_trans_o.address       = calc_offset;
    end
  end

endmodule

// File: tb/tb_hyperbus_trans_splitter.sv
module tb_hyperbus_trans_splitter;
  import hyperbus_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      in_valid, in_ready;
  up_trans_t in_trans;
  logic      out_valid, out_ready;
  trans_t    out_trans;
  logic      chunk_done, chunk_err;
  logic      done, err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  trans_t exp_q[$];
  logic   exp_err_q[$];

  typedef struct {
    up_trans_t   in;
    int unsigned stall;
    int unsigned err_chunk;
    int unsigned first;
    int unsigned n;
    logic        exp_err;
  } vec_t;

  vec_t   vecs[13];
  trans_t chunk_tab[11];

  always #5 clk = ~clk;

  hyperbus_trans_splitter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_trans_i   (in_trans),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_trans_o  (out_trans),
    .chunk_done_i (chunk_done),
    .chunk_err_i  (chunk_err),
    .done_o       (done),
    .err_o        (err)
  );

  function automatic up_trans_t mk_up(input logic w, input logic [11:0] b, input logic bt,
                                      input logic sp, input logic [31:0] a);
    up_trans_t u;
    u.write = w; u.burst = b; u.burst_type = bt; u.address_space = sp; u.address = a;
    return u;
  endfunction

  function automatic trans_t mk_tr(input logic [1:0] cs, input logic w, input logic [11:0] b,
                                   input logic bt, input logic sp, input logic [31:0] a);
    trans_t t;
    t.cs = cs; t.write = w; t.burst = b; t.burst_type = bt; t.address_space = sp; t.address = a;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one upstream transaction and plays the downstream side. Expected
  // chunks and the expected completion error are already queued by the caller.
  task automatic run_txn(input up_trans_t t, input int unsigned n, input int unsigned stall,
                         input int unsigned err_chunk, input int unsigned early_hs);
    logic        acc;
    logic        exp_err;
    int unsigned cyc;
    int unsigned got;
    int unsigned stall_left;
    exp_err  = exp_err_q.pop_front();
    in_trans = t;
    in_valid = 1'b1;
    cyc      = 0;
    do begin
      acc = in_ready;
      tick();
      cyc++;
    end while (!acc && cyc < 20);
    in_valid = 1'b0;
    in_trans = '0;
    check("accept", acc, 1'b1);
    if (!acc) return;

    if (n == 0) begin
      check("err_no_valid", out_valid, 1'b0);
      check("err_done_early", done, 1'b0);
      tick();
      check("err_done", done, 1'b1);
      check("err_flag", err, exp_err);
      check("err_no_valid2", out_valid, 1'b0);
      tick();
      check("err_pulse_end", done, 1'b0);
      check("ready_after_err", in_ready, 1'b1);
      return;
    end

    got        = 0;
    stall_left = stall;
    cyc        = 0;
    while (got < n && cyc < 2000) begin
      chunk_done = 1'b0;
      chunk_err  = 1'b0;
      if (out_valid) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          if (exp_q.size() != 0) check("stall_hold", out_trans, exp_q[0]);
        end else begin
          out_ready  = 1'b1;
          got++;
          stall_left = stall;
          if (exp_q.size() == 0) check("extra_chunk", out_valid, 1'b0);
          else check("chunk", out_trans, exp_q.pop_front());
          if (got == early_hs) begin
            chunk_done = 1'b1;
            chunk_err  = (err_chunk == 1);
          end
        end
      end else begin
        out_ready = 1'b0;
      end
      tick();
      cyc++;
    end
    out_ready  = 1'b0;
    chunk_done = 1'b0;
    chunk_err  = 1'b0;
    check("issue_count", got, n);
    check("no_extra_valid", out_valid, 1'b0);

    for (int unsigned i = (early_hs != 0) ? 2 : 1; i <= got; i++) begin
      check("done_early", done, 1'b0);
      chunk_done = 1'b1;
      chunk_err  = (i == err_chunk);
      tick();
      chunk_done = 1'b0;
      chunk_err  = 1'b0;
    end
    check("done", done, 1'b1);
    check("done_err", err, exp_err);
    tick();
    check("done_pulse_end", done, 1'b0);
    check("ready_after", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    int unsigned cyc;

    rst_n = 1'b0; in_valid = 1'b0; in_trans = '0;
    out_ready = 1'b0; chunk_done = 1'b0; chunk_err = 1'b0;

    chunk_tab[0]  = mk_tr(2'b01, 1'b0, 12'd10, 1'b1, 1'b0, 32'h0000_0000);
    chunk_tab[1]  = mk_tr(2'b01, 1'b1, 12'd8,  1'b1, 1'b0, 32'h0000_0070);
    chunk_tab[2]  = mk_tr(2'b01, 1'b1, 12'd64, 1'b1, 1'b0, 32'h0000_0080);
    chunk_tab[3]  = mk_tr(2'b01, 1'b1, 12'd28, 1'b1, 1'b0, 32'h0000_0100);
    chunk_tab[4]  = mk_tr(2'b01, 1'b0, 12'd32, 1'b1, 1'b0, 32'h007F_FFC0);
    chunk_tab[5]  = mk_tr(2'b10, 1'b0, 12'd32, 1'b1, 1'b0, 32'h0000_0000);
    chunk_tab[6]  = mk_tr(2'b01, 1'b0, 12'd16, 1'b0, 1'b0, 32'h0000_0070);
    chunk_tab[7]  = mk_tr(2'b10, 1'b0, 12'd1,  1'b1, 1'b1, 32'h0000_0002);
    chunk_tab[8]  = mk_tr(2'b10, 1'b1, 12'd1,  1'b1, 1'b0, 32'h007F_FFFE);
    chunk_tab[9]  = mk_tr(2'b01, 1'b0, 12'd64, 1'b1, 1'b0, 32'h0000_0080);
    chunk_tab[10] = mk_tr(2'b01, 1'b0, 12'd1,  1'b1, 1'b0, 32'h0000_0100);

    vecs[0]  = '{mk_up(1'b0, 12'd10,  1'b1, 1'b0, 32'h0000_0000), 0, 0, 0, 1, 1'b0};
    vecs[1]  = '{mk_up(1'b1, 12'd100, 1'b1, 1'b0, 32'h0000_0070), 0, 0, 1, 3, 1'b0};
    vecs[2]  = '{mk_up(1'b0, 12'd64,  1'b1, 1'b0, 32'h007F_FFC0), 0, 0, 4, 2, 1'b0};
    vecs[3]  = '{mk_up(1'b0, 12'd16,  1'b0, 1'b0, 32'h0000_0070), 0, 0, 6, 1, 1'b0};
    vecs[4]  = '{mk_up(1'b0, 12'd1,   1'b1, 1'b1, 32'h0080_0002), 0, 0, 7, 1, 1'b0};
    vecs[5]  = '{mk_up(1'b1, 12'd1,   1'b1, 1'b0, 32'h00FF_FFFE), 0, 0, 8, 1, 1'b0};
    vecs[6]  = '{mk_up(1'b0, 12'd65,  1'b1, 1'b0, 32'h0000_0080), 2, 1, 9, 2, 1'b1};
    vecs[7]  = '{mk_up(1'b0, 12'd8,   1'b1, 1'b0, 32'h0100_0000), 0, 0, 0, 0, 1'b1};
    vecs[8]  = '{mk_up(1'b0, 12'd0,   1'b1, 1'b0, 32'h0000_0100), 0, 0, 0, 0, 1'b1};
    vecs[9]  = '{mk_up(1'b0, 12'd4,   1'b1, 1'b0, 32'h0000_0003), 0, 0, 0, 0, 1'b1};
    vecs[10] = '{mk_up(1'b0, 12'd65,  1'b0, 1'b0, 32'h0000_0000), 0, 0, 0, 0, 1'b1};
    vecs[11] = '{mk_up(1'b1, 12'd65,  1'b1, 1'b1, 32'h0000_0000), 0, 0, 0, 0, 1'b1};
    vecs[12] = '{mk_up(1'b0, 12'd2,   1'b1, 1'b0, 32'h00FF_FFFE), 0, 0, 0, 0, 1'b1};

    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_trans", out_trans, '0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    check("ready_before_edge", in_ready, 1'b0);
    tick();
    check("ready_after_reset", in_ready, 1'b1);

    for (int unsigned v = 0; v < 13; v++) begin
      for (int unsigned k = 0; k < vecs[v].n; k++) exp_q.push_back(chunk_tab[vecs[v].first + k]);
      exp_err_q.push_back(vecs[v].exp_err);
      run_txn(vecs[v].in, vecs[v].n, vecs[v].stall, vecs[v].err_chunk, 0);
    end

    // 130 words with 5-cycle stalls; chunk 1 completes with error in the
    // same cycle as the chunk 3 handshake.
    exp_q.push_back(mk_tr(2'b01, 1'b1, 12'd64, 1'b1, 1'b0, 32'h0000_0000));
    exp_q.push_back(mk_tr(2'b01, 1'b1, 12'd64, 1'b1, 1'b0, 32'h0000_0080));
    exp_q.push_back(mk_tr(2'b01, 1'b1, 12'd2,  1'b1, 1'b0, 32'h0000_0100));
    exp_err_q.push_back(1'b1);
    run_txn(mk_up(1'b1, 12'd130, 1'b1, 1'b0, 32'h0000_0000), 3, 5, 1, 3);

    // Reset in the middle of an issuing burst.
    in_trans = mk_up(1'b0, 12'd130, 1'b1, 1'b0, 32'h0000_0000);
    in_valid = 1'b1;
    cyc = 0;
    do begin
      acc = in_ready;
      tick();
      cyc++;
    end while (!acc && cyc < 20);
    in_valid = 1'b0;
    check("rst_seq_accept", acc, 1'b1);
    tick();
    check("rst_seq_issuing", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_trans", out_trans, '0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check("midrst_ready_release", in_ready, 1'b0);
    tick();
    check("midrst_ready_after", in_ready, 1'b1);
    for (int unsigned i = 0; i < 3; i++) begin
      chunk_done = 1'b1;
      chunk_err  = 1'b1;
      tick();
      check("stray_done", done, 1'b0);
      check("stray_valid", out_valid, 1'b0);
    end
    chunk_done = 1'b0;
    chunk_err  = 1'b0;
    tick();
    check("stray_done_after", done, 1'b0);
    exp_q.push_back(chunk_tab[0]);
    exp_err_q.push_back(1'b0);
    run_txn(vecs[0].in, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
